// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two RAM masters, the arbiter and the single-port data RAM.
interface ram_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_ready;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_ready;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;
  logic [1:0]        owner;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  ram_dout,
    output m0_ack, m0_rdata, m0_ready,
    output m1_ack, m1_rdata, m1_ready,
    output ram_addr, ram_we, ram_din, owner
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output ram_dout,
    input  m0_ack, m0_rdata, m0_ready,
    input  m1_ack, m1_rdata, m1_ready,
    input  ram_addr, ram_we, ram_din, owner
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-master arbiter for the single-port data RAM: fixed 4-cycle transactions,
// M0 priority with M1 forced after M1_MAX_WAIT consecutive M0 grants.
module ram_arbiter #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int M1_MAX_WAIT = 4
) (
  input  logic           clk,
  input  logic           rst,
  ram_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_e;

  localparam logic [3:0] MAX_WAIT = 4'(M1_MAX_WAIT);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              we_q, we_d;
  logic              ram_we_q, ram_we_d;
  logic [1:0]        owner_q, owner_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [3:0]        wait_q, wait_d;
  logic              grant_m1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      din_q    <= '0;
      we_q     <= 1'b0;
      ram_we_q <= 1'b0;
      owner_q  <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      we_q     <= we_d;
      ram_we_q <= ram_we_d;
      owner_q  <= owner_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      wait_q   <= wait_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    din_d    = din_q;
    we_d     = we_q;
    ram_we_d = 1'b0;
    owner_d  = owner_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    wait_d   = wait_q;
    grant_m1 = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!bus.m1_req) wait_d = '0;
        if (bus.m0_req || bus.m1_req) begin
          grant_m1 = bus.m1_req && (!bus.m0_req || (wait_q == MAX_WAIT));
          if (grant_m1) begin
            owner_d = 2'b10;
            addr_d  = bus.m1_addr;
            din_d   = bus.m1_wdata;
            we_d    = bus.m1_we;
            wait_d  = '0;
          end else begin
            owner_d = 2'b01;
            addr_d  = bus.m0_addr;
            din_d   = bus.m0_wdata;
            we_d    = bus.m0_we;
            if (bus.m1_req && (wait_q < MAX_WAIT)) wait_d = wait_q + 4'd1;
          end
          // Registered write strobe is high only for the ISSUE cycle that follows.
          ram_we_d = grant_m1 ? bus.m1_we : bus.m0_we;
          state_d  = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        state_d = ACK;
        if (owner_q[1]) begin
          ack1_d = 1'b1;
          if (!we_q) rdata1_d = bus.ram_dout;
        end else begin
          ack0_d = 1'b1;
          if (!we_q) rdata0_d = bus.ram_dout;
        end
      end
      ACK: begin
        state_d = IDLE;
        owner_d = '0;
      end
    endcase
  end

  assign bus.ram_addr = addr_q;
  assign bus.ram_din  = din_q;
  assign bus.ram_we   = ram_we_q;
  assign bus.owner    = owner_q;
  assign bus.m0_ack   = ack0_q;
  assign bus.m1_ack   = ack1_q;
  assign bus.m0_rdata = rdata0_q;
  assign bus.m1_rdata = rdata1_q;
  assign bus.m0_ready = ~bus.m0_req | ack0_q;
  assign bus.m1_ready = ~bus.m1_req | ack1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: transaction-level model checked every cycle, plus literal
// expectations for reset abort, read-back data, latency and grant order.
module tb_ram_arbiter;
  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int MAXW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .M1_MAX_WAIT(MAXW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= mem[bus.ram_addr];
  end

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endfunction

  // Values captured by stimulus, judged by the compare process
  logic [31:0] cap_rd0, cap_rd1, dummy_rd;
  logic        cap_we_pre, cap_we_rst, cap_rst_ack;
  logic [1:0]  cap_own_rst;
  logic [AW-1:0] cap_addr_rst;
  int          lat [4];
  int          stall [4];
  bit          tmo = 1'b0;
  bit          done = 1'b0;
  bit          log4 = 1'b0, log5 = 1'b0;
  int          q4[$], q5[$];

  // Transaction-level model: phase 0 idle, 1..3 = cycles after the grant
  int            phase = 0;
  bit            win = 1'b0;
  bit            ewe = 1'b0;
  logic [AW-1:0] eaddr = '0;
  logic [DW-1:0] edin = '0, er0 = '0, er1 = '0;
  int            wc = 0;
  logic [1:0]    own = '0;
  logic [1:0]    prev_owner = '0;
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  initial begin : compare
    int exp4 [10];
    int exp5 [8];
    exp4 = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
    exp5 = '{1, 1, 1, 1, 1, 1, 1, 2};
    forever begin
      @(negedge clk);
      if (done) break;
      if (rst) begin
        phase = 0; wc = 0; own = '0; ewe = 1'b0; win = 1'b0;
        eaddr = '0; edin = '0; er0 = '0; er1 = '0;
      end
      chk("owner",    bus.owner,    own);
      chk("ram_we",   bus.ram_we,   (phase == 1) && ewe);
      chk("ram_addr", bus.ram_addr, eaddr);
      chk("ram_din",  bus.ram_din,  edin);
      chk("m0_ack",   bus.m0_ack,   (phase == 3) && !win);
      chk("m1_ack",   bus.m1_ack,   (phase == 3) && win);
      chk("m0_rdata", bus.m0_rdata, er0);
      chk("m1_rdata", bus.m1_rdata, er1);
      chk("m0_ready", bus.m0_ready, !bus.m0_req || ((phase == 3) && !win));
      chk("m1_ready", bus.m1_ready, !bus.m1_req || ((phase == 3) && win));
      chk("timeout",  tmo, 1'b0);

      if (bus.owner != 2'b00 && prev_owner == 2'b00) begin
        if (log4) q4.push_back(int'(bus.owner));
        if (log5) q5.push_back(int'(bus.owner));
      end
      prev_owner = bus.owner;

      if (!rst) begin
        case (phase)
          0: begin
            if (!bus.m1_req) wc = 0;
            if (bus.m0_req || bus.m1_req) begin
              win = bus.m1_req && (!bus.m0_req || wc == MAXW);
              if (win) wc = 0;
              else if (bus.m1_req && wc < MAXW) wc = wc + 1;
              own   = win ? 2'b10 : 2'b01;
              ewe   = win ? bus.m1_we    : bus.m0_we;
              eaddr = win ? bus.m1_addr  : bus.m0_addr;
              edin  = win ? bus.m1_wdata : bus.m0_wdata;
              phase = 1;
            end
          end
          1: begin
            if (ewe) ref_mem[eaddr] = edin;
            phase = 2;
          end
          2: begin
            if (!ewe) begin
              if (win) er1 = ref_mem[eaddr];
              else     er0 = ref_mem[eaddr];
            end
            phase = 3;
          end
          default: begin
            phase = 0;
            own = '0;
          end
        endcase
      end
    end

    chk("rst_we_before", cap_we_pre,   1'b1);
    chk("rst_we_async",  cap_we_rst,   1'b0);
    chk("rst_owner",     cap_own_rst,  2'b00);
    chk("rst_addr",      cap_addr_rst, '0);
    chk("rst_no_ack",    cap_rst_ack,  1'b0);
    chk("m0_readback",   cap_rd0, 32'hDEADBEEF);
    chk("m1_readback",   cap_rd1, 32'h12345678);
    for (int i = 0; i < 4; i++) chk($sformatf("latency%0d", i), lat[i], 3);
    chk("m0_stall_wr", stall[0], 3);
    chk("m0_stall_rd", stall[1], 3);
    chk("grants4_len", q4.size(), 10);
    for (int i = 0; i < 10 && i < q4.size(); i++) chk($sformatf("grant4_%0d", i), q4[i], exp4[i]);
    chk("grants5_len", q5.size(), 8);
    for (int i = 0; i < 8 && i < q5.size(); i++) chk($sformatf("grant5_%0d", i), q5[i], exp5[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic access(input bit m, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output logic [DW-1:0] rd,
                        output int l, output int st);
    if (!m) begin
      bus.m0_req = 1'b1; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d;
    end else begin
      bus.m1_req = 1'b1; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d;
    end
    l = -1; st = 0; rd = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (m ? bus.m1_ack : bus.m0_ack) begin
        l  = k;
        rd = m ? bus.m1_rdata : bus.m0_rdata;
        break;
      end
      if (!(m ? bus.m1_ready : bus.m0_ready)) st++;
    end
    if (l < 0) tmo = 1'b1;
    @(posedge clk); #1;
    if (!m) bus.m0_req = 1'b0;
    else    bus.m1_req = 1'b0;
  endtask

  initial begin : stimulus
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
    cap_rst_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset in the ISSUE cycle of a write must abort it without a clock edge
    bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 10'h055; bus.m0_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    cap_we_pre = bus.ram_we;
    rst = 1'b1;
    #1;
    cap_we_rst   = bus.ram_we;
    cap_own_rst  = bus.owner;
    cap_addr_rst = bus.ram_addr;
    bus.m0_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.m0_ack) cap_rst_ack = 1'b1;
    end
    @(posedge clk); #1;

    access(1'b0, 1'b1, 10'h0A5, 32'hDEADBEEF, dummy_rd, lat[0], stall[0]);
    access(1'b0, 1'b0, 10'h0A5, 32'h0,        cap_rd0,  lat[1], stall[1]);
    access(1'b1, 1'b1, 10'h3FF, 32'h12345678, dummy_rd, lat[2], stall[2]);
    access(1'b1, 1'b0, 10'h3FF, 32'h0,        cap_rd1,  lat[3], stall[3]);

    // Both masters requesting continuously
    log4 = 1'b1;
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 10'h0A5;
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 10'h3FF;
    repeat (40) @(posedge clk);
    #1 bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    log4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // M1 drops for one IDLE cycle after two M0 grants, restarting its wait count
    log5 = 1'b1;
    bus.m0_req = 1'b1;
    bus.m1_req = 1'b1;
    repeat (8) @(posedge clk);
    #1 bus.m1_req = 1'b0;
    @(posedge clk);
    #1 bus.m1_req = 1'b1;
    repeat (23) @(posedge clk);
    #1 bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    log5 = 1'b0;
    repeat (3) @(posedge clk);
    #1 done = 1'b1;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
